// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the EX stage: computes the result at start,
// holds it in a shadow register, and commits HI/LO together after a fixed latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // 64-bit product; signed ops sign-extend both operands first.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ae;
    logic [63:0] be;
    ae = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    be = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes, which
  // also yields the 0x80000000 / -1 overflow case (quotient 0x80000000, rem 0).
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;
    q     = ma / mb;
    r     = ma % mb;
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      shi_q, shi_d;
  logic [31:0]      slo_q, slo_d;
  logic [63:0]      prod;
  logic [63:0]      qr;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    shi_d  = shi_q;
    slo_d  = slo_q;
    prod   = mul64(A, B, MDUOp == OP_MULT);
    qr     = div64(A, B, MDUOp == OP_DIV);
    if (busy_q) begin
      // Commit takes priority over any Start presented on the same edge.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        hi_d   = shi_q;
        lo_d   = slo_q;
      end
    end else if (Start) begin
      case (MDUOp)
        OP_MULT, OP_MULTU: begin
          {shi_d, slo_d} = prod;
          busy_d         = 1'b1;
          cnt_d          = CNT_W'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero commits the current HI/LO back, leaving them unchanged.
          if (B == 32'd0) {shi_d, slo_d} = {hi_q, lo_q};
          else            {shi_d, slo_d} = qr;
          busy_d = 1'b1;
          cnt_d  = CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Shadow result is only consumed while busy, so a reset simply orphans it.
  always_ff @(posedge clk) begin
    shi_q <= shi_d;
    slo_q <= slo_d;
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
